// File: rtl/conv_layer_ctrl.sv
// Convolution-layer sequencer: walks oc/oy/ox-pair/tap space and drives the BRAM reads, MAC enables and write-back.
// Reads issue 1 cycle ahead of mac_en; w_rd_vld low freezes tap issue; start is edge-triggered.
module conv_layer_ctrl #(
    parameter int K      = 5,
    parameter int IN_W   = 32,
    parameter int IN_H   = 32,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 6,
    parameter int FM_AW  = 12,
    parameter int W_AW   = 12,
    parameter int B_AW   = 7,
    parameter int O_AW   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             w_rd_vld,
    output logic             busy,
    output logic             done,
    output logic             bias_en,
    output logic [B_AW-1:0]  bias_addr,
    output logic             w_en,
    output logic [W_AW-1:0]  w_addr,
    output logic             fm_ena,
    output logic             fm_enb,
    output logic [FM_AW-1:0] fm_addra,
    output logic [FM_AW-1:0] fm_addrb,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             acc_last,
    output logic             out_we,
    output logic [O_AW-1:0]  out_addr
);
    localparam int OUT_W = IN_W - K + 1;
    localparam int OUT_H = IN_H - K + 1;
    localparam int T     = K * K * IN_CH;
    localparam int CW    = 16;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t K_MAX  = cnt_t'(K - 1);
    localparam cnt_t IC_MAX = cnt_t'(IN_CH - 1);
    localparam cnt_t OX_MAX = cnt_t'(OUT_W - 2);
    localparam cnt_t OY_MAX = cnt_t'(OUT_H - 1);
    localparam cnt_t OC_MAX = cnt_t'(OUT_CH - 1);
    localparam logic [FM_AW-1:0] FM_ROW   = FM_AW'(IN_W);
    localparam logic [FM_AW-1:0] FM_PLANE = FM_AW'(IN_H * IN_W);
    localparam logic [W_AW-1:0]  W_OC     = W_AW'(T);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_TAP, S_WAIT, S_WR, S_DONE} state_t;

    state_t state, state_nxt;
    logic   start_d;
    cnt_t   oc, oy, ox, ic, ky, kx;
    logic [W_AW-1:0]  w_base, w_a, w_base_nxt;
    logic [FM_AW-1:0] fm_a, fm_b, fm_row, fm_ch, pos, pos_row;
    logic [FM_AW-1:0] pos_nxt, pos_row_nxt, fm_row_tap, fm_ch_tap;
    logic [O_AW-1:0]  o_addr;
    logic mac_en_q, mac_clr_q, acc_last_q;

    logic start_edge, issue;
    logic last_kx, last_ky, last_ic, first_tap, last_tap;
    logic last_ox, last_oy, last_oc, oc_end, layer_end;

    assign start_edge = start & ~start_d;
    assign issue      = (state == S_TAP) & w_rd_vld;
    assign last_kx    = (kx == K_MAX);
    assign last_ky    = (ky == K_MAX);
    assign last_ic    = (ic == IC_MAX);
    assign first_tap  = (kx == '0) & (ky == '0) & (ic == '0);
    assign last_tap   = last_kx & last_ky & last_ic;
    assign last_ox    = (ox == OX_MAX);
    assign last_oy    = (oy == OY_MAX);
    assign last_oc    = (oc == OC_MAX);
    assign oc_end     = last_ox & last_oy;
    assign layer_end  = oc_end & last_oc;

    assign fm_row_tap = fm_row + FM_ROW;
    assign fm_ch_tap  = fm_ch + FM_PLANE;

    // Window origin and weight base for the pair that follows the current WR.
    always_comb begin
        pos_row_nxt = pos_row;
        pos_nxt     = pos + FM_AW'(2);
        w_base_nxt  = w_base;
        if (last_ox) begin
            if (last_oy) begin
                pos_row_nxt = '0;
                pos_nxt     = '0;
                w_base_nxt  = last_oc ? '0 : w_base + W_OC;
            end else begin
                pos_row_nxt = pos_row + FM_ROW;
                pos_nxt     = pos_row + FM_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        bias_en   = 1'b0;
        out_we    = 1'b0;
        w_en      = issue;
        fm_ena    = issue;
        fm_enb    = issue;
        case (state)
            S_IDLE: if (start_edge) state_nxt = S_BIAS;
            S_BIAS: begin
                bias_en   = 1'b1;
                state_nxt = S_TAP;
            end
            S_TAP:  if (issue && last_tap) state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_WR;
            S_WR: begin
                out_we = 1'b1;
                if (layer_end)   state_nxt = S_DONE;
                else if (oc_end) state_nxt = S_BIAS;
                else             state_nxt = S_TAP;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_d <= 1'b0;
            {oc, oy, ox, ic, ky, kx} <= '0;
            w_base <= '0;  w_a <= '0;
            fm_a <= '0;  fm_b <= '0;  fm_row <= '0;  fm_ch <= '0;
            pos <= '0;  pos_row <= '0;  o_addr <= '0;
            mac_en_q <= 1'b0;  mac_clr_q <= 1'b0;  acc_last_q <= 1'b0;
        end else begin
            start_d    <= start;
            mac_en_q   <= issue;
            mac_clr_q  <= issue & first_tap;
            acc_last_q <= issue & last_tap;
            case (state)
                S_IDLE: if (start_edge) begin
                    {oc, oy, ox, ic, ky, kx} <= '0;
                    w_base <= '0;  w_a <= '0;
                    fm_a <= '0;  fm_b <= FM_AW'(1);  fm_row <= '0;  fm_ch <= '0;
                    pos <= '0;  pos_row <= '0;  o_addr <= '0;
                end
                S_TAP: if (w_rd_vld) begin
                    w_a <= w_a + W_AW'(1);
                    if (!last_kx) begin
                        kx   <= kx + cnt_t'(1);
                        fm_a <= fm_a + FM_AW'(1);
                        fm_b <= fm_b + FM_AW'(1);
                    end else begin
                        kx <= '0;
                        if (!last_ky) begin
                            ky     <= ky + cnt_t'(1);
                            fm_row <= fm_row_tap;
                            fm_a   <= fm_row_tap;
                            fm_b   <= fm_row_tap + FM_AW'(1);
                        end else begin
                            ky <= '0;
                            if (!last_ic) begin
                                ic     <= ic + cnt_t'(1);
                                fm_ch  <= fm_ch_tap;
                                fm_row <= fm_ch_tap;
                                fm_a   <= fm_ch_tap;
                                fm_b   <= fm_ch_tap + FM_AW'(1);
                            end else begin
                                ic <= '0;
                            end
                        end
                    end
                end
                S_WR: begin
                    o_addr <= layer_end ? '0 : o_addr + O_AW'(1);
                    ox     <= last_ox ? '0 : ox + cnt_t'(2);
                    if (last_ox) begin
                        oy <= last_oy ? '0 : oy + cnt_t'(1);
                        if (last_oy) oc <= last_oc ? '0 : oc + cnt_t'(1);
                    end
                    pos     <= pos_nxt;
                    pos_row <= pos_row_nxt;
                    w_base  <= w_base_nxt;
                    w_a     <= w_base_nxt;
                    fm_a    <= pos_nxt;
                    fm_row  <= pos_nxt;
                    fm_ch   <= pos_nxt;
                    fm_b    <= layer_end ? '0 : pos_nxt + FM_AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bias_addr = B_AW'(oc);
    assign w_addr    = w_a;
    assign fm_addra  = fm_a;
    assign fm_addrb  = fm_b;
    assign out_addr  = o_addr;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign acc_last  = acc_last_q;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench: default LeNet C1 instance plus a small K=3 / 2-channel instance.
module tb_conv_layer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_rd_vld = 1'b1;
    logic [1:0] start_s = 2'b00;
    logic [1:0] busy_s, done_s, bias_en_s, w_en_s, fm_ena_s, fm_enb_s;
    logic [1:0] mac_clr_s, mac_en_s, acc_last_s, out_we_s;
    logic [1:0][6:0]  bias_addr_s;
    logic [1:0][11:0] w_addr_s, fm_addra_s, fm_addrb_s, out_addr_s;

    int sel = 0, tick = 0, t0 = 0, wr_seen = 0;
    int n_checks = 0, n_fail = 0;

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int cyc; int sig; int val; } pr_t;
    ev_t bias_q[$], wr_q[$], done_q[$];
    pr_t pr_q[$];

    localparam int P_ALL = 0, P_WADDR = 1, P_FMA = 2, P_FMB = 3, P_WEN = 4;
    localparam int P_MACEN = 5, P_MACCLR = 6, P_ACCLAST = 7, P_BUSY = 8;
    string sname[9] = '{"any_output", "w_addr", "fm_addra", "fm_addrb", "w_en",
                        "mac_en", "mac_clr", "acc_last", "busy"};

    conv_layer_ctrl dut (
        .clk(clk), .rst(rst), .start(start_s[0]), .w_rd_vld(w_rd_vld),
        .busy(busy_s[0]), .done(done_s[0]), .bias_en(bias_en_s[0]), .bias_addr(bias_addr_s[0]),
        .w_en(w_en_s[0]), .w_addr(w_addr_s[0]), .fm_ena(fm_ena_s[0]), .fm_enb(fm_enb_s[0]),
        .fm_addra(fm_addra_s[0]), .fm_addrb(fm_addrb_s[0]), .mac_clr(mac_clr_s[0]),
        .mac_en(mac_en_s[0]), .acc_last(acc_last_s[0]), .out_we(out_we_s[0]), .out_addr(out_addr_s[0])
    );

    conv_layer_ctrl #(.K(3), .IN_W(6), .IN_H(6), .IN_CH(2), .OUT_CH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .w_rd_vld(w_rd_vld),
        .busy(busy_s[1]), .done(done_s[1]), .bias_en(bias_en_s[1]), .bias_addr(bias_addr_s[1]),
        .w_en(w_en_s[1]), .w_addr(w_addr_s[1]), .fm_ena(fm_ena_s[1]), .fm_enb(fm_enb_s[1]),
        .fm_addra(fm_addra_s[1]), .fm_addrb(fm_addrb_s[1]), .mac_clr(mac_clr_s[1]),
        .mac_en(mac_en_s[1]), .acc_last(acc_last_s[1]), .out_we(out_we_s[1]), .out_addr(out_addr_s[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int get_sig(input int s);
        case (s)
            P_ALL: return int'(|{busy_s[sel], done_s[sel], bias_en_s[sel], bias_addr_s[sel],
                                 w_en_s[sel], w_addr_s[sel], fm_ena_s[sel], fm_enb_s[sel],
                                 fm_addra_s[sel], fm_addrb_s[sel], mac_clr_s[sel], mac_en_s[sel],
                                 acc_last_s[sel], out_we_s[sel], out_addr_s[sel]});
            P_WADDR:   return int'(w_addr_s[sel]);
            P_FMA:     return int'(fm_addra_s[sel]);
            P_FMB:     return int'(fm_addrb_s[sel]);
            P_WEN:     return int'(w_en_s[sel] & fm_ena_s[sel] & fm_enb_s[sel]);
            P_MACEN:   return int'(mac_en_s[sel]);
            P_MACCLR:  return int'(mac_clr_s[sel]);
            P_ACCLAST: return int'(acc_last_s[sel]);
            P_BUSY:    return int'(busy_s[sel]);
            default:   return -1;
        endcase
    endfunction

    function automatic void pr(input int c, input int s, input int v);
        pr_q.push_back('{c, s, v});
    endfunction

    // Monitor: pops the scoreboard whenever the selected DUT strobes an output.
    always @(negedge clk) begin : mon
        int rel;
        ev_t e;
        pr_t p;
        rel = tick - t0;
        if (bias_en_s[sel]) begin
            if (bias_q.size() == 0) chk("unexpected bias_en at cycle", rel, -1);
            else begin
                e = bias_q.pop_front();
                chk($sformatf("bias_en cycle(oc %0d)", e.val), rel, e.cyc);
                chk("bias_addr", int'(bias_addr_s[sel]), e.val);
            end
        end
        if (out_we_s[sel]) begin
            wr_seen++;
            if (wr_q.size() == 0) chk("unexpected out_we at cycle", rel, -1);
            else begin
                e = wr_q.pop_front();
                chk($sformatf("out_we cycle(pair %0d)", e.val), rel, e.cyc);
                chk("out_addr", int'(out_addr_s[sel]), e.val);
            end
        end
        if (done_s[sel]) begin
            if (done_q.size() == 0) chk("unexpected done at cycle", rel, -1);
            else begin
                e = done_q.pop_front();
                chk("done cycle", rel, e.cyc);
            end
        end
        while (pr_q.size() != 0 && pr_q[0].cyc <= rel) begin
            p = pr_q.pop_front();
            chk($sformatf("%s@%0d", sname[p.sig], p.cyc),
                (p.cyc == rel) ? get_sig(p.sig) : -1, p.val);
        end
    end

    task automatic go_to(input int r);
        while (tick - t0 < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_run(input int which);
        @(posedge clk);
        #1;
        sel = which;
        start_s[which] = 1'b1;
        t0 = tick;
        wr_seen = 0;
    endtask

    task automatic end_phase(input string nm);
        chk({nm, " bias events missing"}, bias_q.size(), 0);
        chk({nm, " out_we events missing"}, wr_q.size(), 0);
        chk({nm, " done events missing"}, done_q.size(), 0);
        chk({nm, " probes missing"}, pr_q.size(), 0);
        bias_q.delete(); wr_q.delete(); done_q.delete(); pr_q.delete();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        t0 = tick;
        pr(1, P_ALL, 0);
        pr(1, P_BUSY, 0);
        go_to(3);
        rst = 1'b0;
        go_to(5);
        end_phase("reset");

        // Full default layer, re-pulse while busy, start held high past done
        begin_run(0);
        for (int c = 0; c < 6; c++) begin
            bias_q.push_back('{1 + c * 10585, c});
            for (int j = 0; j < 392; j++)
                wr_q.push_back('{28 + c * 10585 + 27 * j, c * 392 + j});
        end
        done_q.push_back('{63511, 0});
        pr(0, P_BUSY, 0);    pr(1, P_BUSY, 1);
        pr(2, P_WADDR, 0);   pr(2, P_FMA, 0);     pr(2, P_FMB, 1);    pr(2, P_WEN, 1);
        pr(3, P_MACCLR, 1);  pr(3, P_MACEN, 1);   pr(4, P_MACCLR, 0);
        pr(7, P_WADDR, 5);   pr(7, P_FMA, 32);    pr(7, P_FMB, 33);
        pr(26, P_ACCLAST, 0); pr(27, P_ACCLAST, 1); pr(27, P_WEN, 0); pr(28, P_MACEN, 0);
        pr(353, P_FMA, 26);  pr(380, P_FMA, 32);
        pr(10587, P_WADDR, 25); pr(10587, P_FMA, 0); pr(10588, P_MACCLR, 1);
        pr(63512, P_BUSY, 0); pr(63550, P_BUSY, 0);
        go_to(100);
        start_s[0] = 1'b0;
        go_to(102);
        start_s[0] = 1'b1;
        go_to(63560);
        chk("out_we total", wr_seen, 2352);
        end_phase("layer");

        // Stall during tap 10 of pair 0, w_rd_vld ignored in BIAS, then reset mid-TAP
        start_s[0] = 1'b0;
        reset_pulse();
        begin_run(0);
        bias_q.push_back('{1, 0});
        wr_q.push_back('{31, 0});
        pr(1, P_BUSY, 1);    pr(2, P_WADDR, 0);   pr(2, P_WEN, 1);
        pr(11, P_WADDR, 9);  pr(12, P_WADDR, 10); pr(12, P_WEN, 0);   pr(12, P_MACEN, 1);
        pr(13, P_WADDR, 10); pr(13, P_MACEN, 0);  pr(14, P_WADDR, 10); pr(14, P_MACEN, 0);
        pr(15, P_WADDR, 10); pr(15, P_WEN, 1);    pr(15, P_MACEN, 0); pr(16, P_MACEN, 1);
        pr(29, P_ACCLAST, 0); pr(30, P_ACCLAST, 1);
        pr(40, P_WEN, 1);    pr(41, P_ALL, 0);    pr(41, P_BUSY, 0);
        go_to(1);  w_rd_vld = 1'b0;
        go_to(2);  w_rd_vld = 1'b1;
        go_to(12); w_rd_vld = 1'b0;
        go_to(15); w_rd_vld = 1'b1;
        go_to(40); rst = 1'b1; start_s[0] = 1'b0;
        go_to(43); rst = 1'b0;
        go_to(120);
        end_phase("stall/abort");

        // Parameter sweep instance: K=3, 6x6, 2 in / 2 out channels
        reset_pulse();
        begin_run(1);
        for (int c = 0; c < 2; c++) begin
            bias_q.push_back('{1 + c * 161, c});
            for (int j = 0; j < 8; j++)
                wr_q.push_back('{21 + c * 161 + 20 * j, c * 8 + j});
        end
        done_q.push_back('{323, 0});
        pr(2, P_WADDR, 0);   pr(22, P_FMA, 2);    pr(42, P_FMA, 6);
        pr(163, P_WADDR, 18); pr(172, P_WADDR, 27); pr(172, P_FMA, 36); pr(172, P_FMB, 37);
        pr(323, P_BUSY, 1);  pr(324, P_BUSY, 0);
        go_to(360);
        chk("sweep out_we total", wr_seen, 16);
        end_phase("sweep");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
